// File: rtl/snake_body_update.sv
// Game-state core of the snake: multi-segment body, apple, score and speed level, advanced once per move frame.
// A move takes 3-5 cycles after the frame edge (MOV, COL, then GROW/SELF_BITE and HANDLED_COL); all outputs are registered.
module snake_body_update #(
   parameter int MAX_LEN    = 8,
   parameter int INIT_LEN   = 4,
   parameter int STEP       = 21,
   parameter int CEIL       = 143,
   parameter int INIT_SPEED = 16,
   parameter int MIN_SPEED  = 2,
   parameter int LVL_APPLES = 6,
   parameter int BLINK_RATE = 72
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         is_listening,
   input  logic                         apple_bite,
   input  logic [3:0]                   mv_dir,
   output logic [MAX_LEN*20-1:0]        snake_pos,
   output logic [MAX_LEN-1:0]           seg_valid,
   output logic [$clog2(MAX_LEN+1)-1:0] len,
   output logic [19:0]                  apple_pos,
   output logic                         vis_apple,
   output logic                         hCol,
   output logic [7:0]                   points,
   output logic                         game_over
);
   localparam int LEN_W = $clog2(MAX_LEN+1);
   localparam int FC_W  = $clog2(CEIL);
   localparam int SPD_W = $clog2(INIT_SPEED+1);
   localparam int LVL_W = (LVL_APPLES > 1) ? $clog2(LVL_APPLES) : 1;
   localparam logic [MAX_LEN-1:0] INIT_MASK = MAX_LEN'((64'd1 << INIT_LEN) - 64'd1);

   typedef enum logic [2:0] {IDLE, MOV, COL, GROW, SELF_BITE, HANDLED_COL} state_t;

   state_t                    state_q, state_d;
   logic [MAX_LEN-1:0][9:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [MAX_LEN-1:0]        seg_valid_q, seg_valid_d;
   logic [9:0]                apple_x_q, apple_x_d, apple_y_q, apple_y_d;
   logic [SPD_W-1:0]          speed_q, speed_d;
   logic [LVL_W-1:0]          lvl_q, lvl_d;
   logic [7:0]                points_q, points_d;
   logic [FC_W-1:0]           frame_ctr_q, frame_ctr_d, cur_frame_q, cur_frame_d;
   logic [2:0]                lfsr_q, lfsr_d;
   logic                      vis_q, vis_d, hcol_q, hcol_d, game_over_q, game_over_d;
   logic                      listen_dly_q, listen_dly_d, bite_dly_q, bite_dly_d;
   logic                      blink_hit_q, blink_hit_d;

   logic [FC_W-1:0]           spd_mask;
   logic [9:0]                nx, ny;
   logic                      onehot, hit, blink_now;

   function automatic logic [9:0] init_y(input int i);
      return 10'(400 + i*STEP);
   endfunction

   function automatic logic [19:0] apple_tab(input logic [2:0] idx);
      case (idx)
         3'd0:    return {10'd450, 10'd5};
         3'd1:    return {10'd150, 10'd200};
         3'd2:    return {10'd750, 10'd550};
         3'd3:    return {10'd10,  10'd10};
         3'd4:    return {10'd670, 10'd300};
         3'd5:    return {10'd275, 10'd500};
         3'd6:    return {10'd100, 10'd150};
         default: return {10'd400, 10'd300};
      endcase
   endfunction

   assign spd_mask = FC_W'(speed_q - 1'b1);

   always_comb begin
      state_d      = state_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      len_d        = len_q;
      apple_x_d    = apple_x_q;
      apple_y_d    = apple_y_q;
      speed_d      = speed_q;
      lvl_d        = lvl_q;
      points_d     = points_q;
      frame_ctr_d  = frame_ctr_q;
      cur_frame_d  = cur_frame_q;
      lfsr_d       = lfsr_q;
      vis_d        = vis_q;
      hcol_d       = hcol_q;
      game_over_d  = 1'b0;
      listen_dly_d = is_listening;
      bite_dly_d   = apple_bite;
      nx           = pos_x_q[0];
      ny           = pos_y_q[0];
      onehot       = 1'b1;
      hit          = 1'b0;

      if (is_listening && !listen_dly_q)
         frame_ctr_d = (frame_ctr_q == FC_W'(CEIL-1)) ? '0 : frame_ctr_q + 1'b1;

      // toggle only on entry into the blink condition, not while it holds
      blink_now   = (frame_ctr_q % FC_W'(BLINK_RATE)) == '0;
      blink_hit_d = blink_now;
      if (blink_now && !blink_hit_q)
         vis_d = ~vis_q;

      if (apple_bite && !bite_dly_q)
         hcol_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_ctr_q != cur_frame_q && (frame_ctr_q & spd_mask) == '0) begin
               cur_frame_d = frame_ctr_q;
               state_d     = MOV;
            end
         end
         MOV: begin
            case (mv_dir)
               4'b0001: ny = (pos_y_q[0] <= 10'd20)  ? 10'd600 : pos_y_q[0] - 10'(STEP);
               4'b0010: ny = (pos_y_q[0] >= 10'd580) ? 10'd0   : pos_y_q[0] + 10'(STEP);
               4'b0100: nx = (pos_x_q[0] <= 10'd20)  ? 10'd800 : pos_x_q[0] - 10'(STEP);
               4'b1000: nx = (pos_x_q[0] >= 10'd780) ? 10'd0   : pos_x_q[0] + 10'(STEP);
               default: onehot = 1'b0;
            endcase
            if (onehot) begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  pos_x_d[i] = pos_x_q[i-1];
                  pos_y_d[i] = pos_y_q[i-1];
               end
               pos_x_d[0] = nx;
               pos_y_d[0] = ny;
            end
            state_d = COL;
         end
         COL: begin
            for (int i = 1; i < MAX_LEN; i++)
               if (LEN_W'(i) < len_q && pos_x_q[i] == pos_x_q[0] && pos_y_q[i] == pos_y_q[0])
                  hit = 1'b1;
            if (hit) begin
               state_d     = SELF_BITE;
               game_over_d = 1'b1;
            end else if (apple_bite) begin
               state_d = GROW;
            end else begin
               state_d = IDLE;
            end
         end
         GROW: begin
            {apple_x_d, apple_y_d} = apple_tab(lfsr_q);
            lfsr_d = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
            // the shift already duplicated the old tail into pos[len]
            if (len_q < LEN_W'(MAX_LEN))
               len_d = len_q + 1'b1;
            if (points_q != 8'hFF)
               points_d = points_q + 8'd1;
            if (lvl_q == LVL_W'(LVL_APPLES-1)) begin
               lvl_d = '0;
               if (speed_q != SPD_W'(MIN_SPEED))
                  speed_d = speed_q >> 1;
            end else begin
               lvl_d = lvl_q + 1'b1;
            end
            state_d = HANDLED_COL;
         end
         SELF_BITE: begin
            for (int i = 0; i < MAX_LEN; i++) begin
               pos_x_d[i] = 10'd300;
               pos_y_d[i] = init_y(i);
            end
            len_d     = LEN_W'(INIT_LEN);
            apple_x_d = 10'd300;
            apple_y_d = 10'd200;
            speed_d   = SPD_W'(INIT_SPEED);
            lvl_d     = '0;
            points_d  = '0;
            hcol_d    = 1'b1;
            state_d   = IDLE;
         end
         HANDLED_COL: begin
            hcol_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      for (int i = 0; i < MAX_LEN; i++)
         seg_valid_d[i] = LEN_W'(i) < len_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         for (int i = 0; i < MAX_LEN; i++) begin
            pos_x_q[i] <= 10'd300;
            pos_y_q[i] <= init_y(i);
         end
         len_q        <= LEN_W'(INIT_LEN);
         seg_valid_q  <= INIT_MASK;
         apple_x_q    <= 10'd300;
         apple_y_q    <= 10'd200;
         speed_q      <= SPD_W'(INIT_SPEED);
         lvl_q        <= '0;
         points_q     <= '0;
         frame_ctr_q  <= '0;
         cur_frame_q  <= '0;
         lfsr_q       <= 3'b001;
         vis_q        <= 1'b1;
         hcol_q       <= 1'b1;
         game_over_q  <= 1'b0;
         listen_dly_q <= 1'b0;
         bite_dly_q   <= 1'b0;
         blink_hit_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         len_q        <= len_d;
         seg_valid_q  <= seg_valid_d;
         apple_x_q    <= apple_x_d;
         apple_y_q    <= apple_y_d;
         speed_q      <= speed_d;
         lvl_q        <= lvl_d;
         points_q     <= points_d;
         frame_ctr_q  <= frame_ctr_d;
         cur_frame_q  <= cur_frame_d;
         lfsr_q       <= lfsr_d;
         vis_q        <= vis_d;
         hcol_q       <= hcol_d;
         game_over_q  <= game_over_d;
         listen_dly_q <= listen_dly_d;
         bite_dly_q   <= bite_dly_d;
         blink_hit_q  <= blink_hit_d;
      end
   end

   always_comb begin
      snake_pos = '0;
      for (int i = 0; i < MAX_LEN; i++)
         snake_pos[i*20 +: 20] = {pos_x_q[i], pos_y_q[i]};
   end

   assign seg_valid = seg_valid_q;
   assign len       = len_q;
   assign apple_pos = {apple_x_q, apple_y_q};
   assign vis_apple = vis_q;
   assign hCol      = hcol_q;
   assign points    = points_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_body_update.sv
// Randomized frame-level bench for snake_body_update against a per-frame behavioural game model.
module tb_snake_body_update;
   localparam int MAX_LEN    = 8;
   localparam int INIT_LEN   = 4;
   localparam int STEP       = 21;
   localparam int CEIL       = 143;
   localparam int INIT_SPEED = 16;
   localparam int MIN_SPEED  = 2;
   localparam int LVL_APPLES = 6;
   localparam int BLINK_RATE = 72;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 is_listening;
   logic                 apple_bite;
   logic [3:0]           mv_dir;
   logic [MAX_LEN*20-1:0] snake_pos;
   logic [MAX_LEN-1:0]   seg_valid;
   logic [3:0]           len;
   logic [19:0]          apple_pos;
   logic                 vis_apple, hCol, game_over;
   logic [7:0]           points;

   snake_body_update dut (
      .clk(clk), .rst(rst), .is_listening(is_listening), .apple_bite(apple_bite),
      .mv_dir(mv_dir), .snake_pos(snake_pos), .seg_valid(seg_valid), .len(len),
      .apple_pos(apple_pos), .vis_apple(vis_apple), .hCol(hCol), .points(points),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int go_cnt = 0;

   always @(posedge clk)
      if (game_over === 1'b1) go_cnt <= go_cnt + 1;

   // behavioural game state, advanced one frame at a time
   int mx[MAX_LEN], my[MAX_LEN];
   int m_len, m_ax, m_ay, m_speed, m_lvl, m_points;
   int m_fc, m_cur, m_lfsr, m_vis, m_hcol, m_go;
   int tab_x[8] = '{450, 150, 750, 10, 670, 275, 100, 400};
   int tab_y[8] = '{5, 200, 550, 10, 300, 500, 150, 300};
   logic last_bite;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic m_body_reset();
      for (int i = 0; i < MAX_LEN; i++) begin
         mx[i] = 300;
         my[i] = 400 + i*STEP;
      end
      m_len = INIT_LEN; m_ax = 300; m_ay = 200;
      m_speed = INIT_SPEED; m_lvl = 0; m_points = 0;
   endtask

   task automatic m_full_reset();
      m_body_reset();
      m_fc = 0; m_cur = 0; m_lfsr = 1; m_vis = 1; m_hcol = 1;
   endtask

   function automatic bit m_will_move();
      int nf;
      nf = (m_fc + 1) % CEIL;
      return nf != m_cur && nf % m_speed == 0;
   endfunction

   task automatic m_frame(input bit rise, input bit bite, input logic [3:0] dir);
      int hx, hy;
      bit hit;
      if (rise) m_hcol = 0;
      m_fc = (m_fc + 1) % CEIL;
      if (m_fc % BLINK_RATE == 0) m_vis = 1 - m_vis;
      if (m_fc != m_cur && m_fc % m_speed == 0) begin
         m_cur = m_fc;
         if (dir == 4'b0001 || dir == 4'b0010 || dir == 4'b0100 || dir == 4'b1000) begin
            hx = mx[0]; hy = my[0];
            case (dir)
               4'b0001: hy = (hy <= 20)  ? 600 : hy - STEP;
               4'b0010: hy = (hy >= 580) ? 0   : hy + STEP;
               4'b0100: hx = (hx <= 20)  ? 800 : hx - STEP;
               default: hx = (hx >= 780) ? 0   : hx + STEP;
            endcase
            for (int i = MAX_LEN-1; i > 0; i--) begin
               mx[i] = mx[i-1];
               my[i] = my[i-1];
            end
            mx[0] = hx; my[0] = hy;
         end
         hit = 0;
         for (int i = 1; i < m_len; i++)
            if (mx[i] == mx[0] && my[i] == my[0]) hit = 1;
         if (hit) begin
            m_body_reset();
            m_hcol = 1;
            m_go++;
         end else if (bite) begin
            m_ax = tab_x[m_lfsr];
            m_ay = tab_y[m_lfsr];
            m_lfsr = ((m_lfsr * 2) % 8) + (((m_lfsr >> 2) ^ (m_lfsr >> 1)) & 1);
            if (m_len < MAX_LEN) m_len++;
            if (m_points < 255) m_points++;
            m_lvl++;
            if (m_lvl == LVL_APPLES) begin
               m_lvl = 0;
               if (m_speed > MIN_SPEED) m_speed = m_speed / 2;
            end
            m_hcol = 1;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < MAX_LEN; i++) begin
         chk_eq($sformatf("pos%0d_x", i), 32'(snake_pos[i*20+10 +: 10]), mx[i]);
         chk_eq($sformatf("pos%0d_y", i), 32'(snake_pos[i*20 +: 10]), my[i]);
      end
      chk_eq("len", 32'(len), m_len);
      chk_eq("seg_valid", 32'(seg_valid), (1 << m_len) - 1);
      chk_eq("apple_x", 32'(apple_pos[19:10]), m_ax);
      chk_eq("apple_y", 32'(apple_pos[9:0]), m_ay);
      chk_eq("points", 32'(points), m_points);
      chk_eq("hCol", 32'(hCol), m_hcol);
      chk_eq("vis_apple", 32'(vis_apple), m_vis);
      chk_eq("game_over_cnt", go_cnt, m_go);
   endtask

   task automatic do_frame(input logic bite, input logic [3:0] dir);
      bit rise;
      rise = bite && !last_bite;
      last_bite = bite;
      apple_bite = bite;
      mv_dir = dir;
      is_listening = 1'b1;
      repeat (2) @(posedge clk);
      #1 is_listening = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      m_frame(rise, bite, dir);
      compare_all();
   endtask

   logic [3:0] cur_dir, dir;
   logic       bite;

   initial begin
      rst = 1'b1; is_listening = 1'b0; apple_bite = 1'b0; mv_dir = 4'b0010;
      last_bite = 1'b0; m_go = 0;
      m_full_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk_eq("rst_head_y", 32'(snake_pos[9:0]), 400);
      rst = 1'b0;

      // 16 frames moving down: observe the head just after the move, then the self-bite restart
      for (int f = 0; f < 15; f++) do_frame(1'b0, 4'b0010);
      is_listening = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("t1_head_x", 32'(snake_pos[19:10]), 300);
      chk_eq("t1_head_y", 32'(snake_pos[9:0]), 421);
      chk_eq("t1_seg1_y", 32'(snake_pos[29:20]), 400);
      chk_eq("t1_len", 32'(len), 4);
      is_listening = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      m_frame(1'b0, 1'b0, 4'b0010);
      compare_all();

      cur_dir = 4'b1000;
      for (int f = 0; f < 2500; f++) begin
         if ($urandom_range(0, 3) == 0) cur_dir = 4'b0001 << $urandom_range(0, 3);
         dir = cur_dir;
         if ($urandom_range(0, 15) == 0) dir = 4'($urandom_range(0, 15));
         bite = ($urandom_range(0, 2) == 0);
         do_frame(bite, dir);
      end

      // async reset in the middle of a bite-driven move
      for (int k = 0; k < 200 && !m_will_move(); k++) do_frame(1'b0, cur_dir);
      apple_bite = 1'b1; mv_dir = cur_dir; is_listening = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      m_full_reset();
      compare_all();
      chk_eq("rst_apple_x", 32'(apple_pos[19:10]), 300);
      chk_eq("rst_points", 32'(points), 0);
      apple_bite = 1'b0; is_listening = 1'b0; last_bite = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      for (int f = 0; f < 16; f++) do_frame(1'b0, 4'b0011);
      chk_eq("nohot_head_x", 32'(snake_pos[19:10]), 300);
      chk_eq("nohot_head_y", 32'(snake_pos[9:0]), 400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
